vga_timing_monitor: RTL

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_if.sv | 41 ++++
 rtl/vga_timing_monitor.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_if.sv
// ---------------------------------------------------------------------------
// vga_if -- raster timing bundle produced by a VGA timing generator.
//
// Signals:
//   hcount [10:0]  horizontal pixel position within the line
//   vcount [10:0]  vertical line position within the frame
//   hsync          horizontal sync strobe
//   vsync          vertical sync strobe
//   hblnk          horizontal blanking strobe
//   vblnk          vertical blanking strobe
//
// Modports:
//   src  -- the generator side (drives everything)
//   mon  -- an observer side (samples everything)
// ---------------------------------------------------------------------------
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport src (
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output hblnk,
    output vblnk
  );

  modport mon (
    input hcount,
    input vcount,
    input hsync,
    input vsync,
    input hblnk,
    input vblnk
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// ---------------------------------------------------------------------------
// vga_timing_monitor -- checks a live VGA timing stream against the raster
// described by the parameters and reports whether it is locked to it.
//
// The monitor waits for a (0,0) sample, then predicts every following pixel
// position with its own expected counters. One clean frame of prediction
// takes it to LOCKED; once locked, any disagreement raises sticky error
// flags, bumps a saturating error counter and drops back to searching.
// Disagreements seen while still tracking (not yet locked) only restart the
// search and are never reported as errors.
//
// Latency: inputs are registered on one edge, compared on the next edge, so
// flags and counters move two clocks after the offending input is presented.
//
// Ports:
//   clk         pixel clock, all logic on its rising edge
//   rst         asynchronous, active-high reset
//   vga_in      timing under test (vga_if.mon)
//   locked      high while in LOCKED
//   err_hcount  sticky: hcount disagreed while locked
//   err_vcount  sticky: vcount disagreed while locked
//   err_sync    sticky: hsync/vsync/hblnk/vblnk disagreed while locked
//   err_count   number of mismatching cycles while locked, saturates at 0xFFFF
//   frame_cnt   number of completed locked frames, wraps modulo 2^16
//
// Build option:
//   VGA_MON_SYNC_CHECK_EN  when defined, the four strobes are compared too;
//                          otherwise only hcount/vcount are compared and
//                          err_sync is constant 0.
// ---------------------------------------------------------------------------
module vga_timing_monitor #(
  parameter int unsigned HOR_TOTAL_TIME  = 1056,
  parameter int unsigned HOR_BLANK_START = 800,
  parameter int unsigned HOR_SYNC_START  = 840,
  parameter int unsigned HOR_SYNC_TIME   = 128,
  parameter int unsigned VER_TOTAL_TIME  = 628,
  parameter int unsigned VER_BLANK_START = 600,
  parameter int unsigned VER_SYNC_START  = 601,
  parameter int unsigned VER_SYNC_TIME   = 4
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.mon          vga_in,
  output logic        locked,
  output logic        err_hcount,
  output logic        err_vcount,
  output logic        err_sync,
  output logic [15:0] err_count,
  output logic [15:0] frame_cnt
);

  // Raster landmarks, pre-sized to the 11-bit counter width so every compare
  // below is a plain unsigned 11-bit compare.
  localparam logic [10:0] H_LAST      = 11'(HOR_TOTAL_TIME - 1);
  localparam logic [10:0] V_LAST      = 11'(VER_TOTAL_TIME - 1);
  localparam logic [10:0] H_BLNK_FROM = 11'(HOR_BLANK_START);
  localparam logic [10:0] H_SYNC_FROM = 11'(HOR_SYNC_START);
  localparam logic [10:0] H_SYNC_TO   = 11'(HOR_SYNC_START + HOR_SYNC_TIME - 1);
  localparam logic [10:0] V_BLNK_FROM = 11'(VER_BLANK_START);
  localparam logic [10:0] V_SYNC_FROM = 11'(VER_SYNC_START);
  localparam logic [10:0] V_SYNC_TO   = 11'(VER_SYNC_START + VER_SYNC_TIME - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // -------------------------------------------------------------------------
  // Input sample registers.
  // Strobe vector bit order: {hsync, vsync, hblnk, vblnk}.
  // smp_vld_reg marks that the sample registers hold a real captured sample;
  // right after reset they read (0,0), which must not be taken as the start
  // of a frame.
  // -------------------------------------------------------------------------
  logic [10:0] h_reg;
  logic [10:0] v_reg;
  logic [3:0]  strb_reg;
  logic        smp_vld_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_reg       <= '0;
      v_reg       <= '0;
      strb_reg    <= '0;
      smp_vld_reg <= 1'b0;
    end else begin
      h_reg       <= vga_in.hcount;
      v_reg       <= vga_in.vcount;
      strb_reg    <= {vga_in.hsync, vga_in.vsync, vga_in.hblnk, vga_in.vblnk};
      smp_vld_reg <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Expected position of the sample currently held in h_reg/v_reg.
  // -------------------------------------------------------------------------
  logic [10:0] exp_h_reg, exp_h_next;
  logic [10:0] exp_v_reg, exp_v_next;

  logic        h_wrap;
  logic        frame_wrap;
  logic [10:0] exp_h_adv;
  logic [10:0] exp_v_adv;

  always_comb begin
    h_wrap     = (exp_h_reg == H_LAST);
    frame_wrap = h_wrap && (exp_v_reg == V_LAST);
    exp_h_adv  = h_wrap ? 11'd0 : exp_h_reg + 11'd1;
    exp_v_adv  = exp_v_reg;
    if (h_wrap) begin
      exp_v_adv = (exp_v_reg == V_LAST) ? 11'd0 : exp_v_reg + 11'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Mismatch detection.
  // -------------------------------------------------------------------------
  logic mis_h;
  logic mis_v;
  logic mis_s;
  logic mismatch;

  assign mis_h = (h_reg != exp_h_reg);
  assign mis_v = (v_reg != exp_v_reg);

`ifdef VGA_MON_SYNC_CHECK_EN
  // Expected strobes, same bit order as strb_reg.
  logic [3:0] strb_exp;
  logic [3:0] strb_mis;

  assign strb_exp[3] = (exp_h_reg >= H_SYNC_FROM) && (exp_h_reg <= H_SYNC_TO);
  assign strb_exp[2] = (exp_v_reg >= V_SYNC_FROM) && (exp_v_reg <= V_SYNC_TO);
  assign strb_exp[1] = (exp_h_reg >= H_BLNK_FROM);
  assign strb_exp[0] = (exp_v_reg >= V_BLNK_FROM);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_strb_cmp
      assign strb_mis[gi] = strb_reg[gi] ^ strb_exp[gi];
    end
  endgenerate

  assign mis_s = |strb_mis;
`else
  // Strobes are still captured (keeps the input stage identical in both
  // builds) but nothing looks at them, so neither do the landmark constants.
  logic unused_strb;
  assign unused_strb = ^{strb_reg, H_SYNC_FROM, H_SYNC_TO, H_BLNK_FROM,
                         V_SYNC_FROM, V_SYNC_TO, V_BLNK_FROM};
  assign mis_s = 1'b0;
`endif

  assign mismatch = mis_h | mis_v | mis_s;

  // -------------------------------------------------------------------------
  // Next-state logic. Only LOCKED reports errors or counts frames; a
  // mismatch on the frame-wrap cycle takes the mismatch branch, so such a
  // frame is never counted.
  // -------------------------------------------------------------------------
  logic set_err_h;
  logic set_err_v;
  logic set_err_s;
  logic err_inc;
  logic frame_inc;

  always_comb begin
    state_next = state_reg;
    exp_h_next = exp_h_reg;
    exp_v_next = exp_v_reg;
    set_err_h  = 1'b0;
    set_err_v  = 1'b0;
    set_err_s  = 1'b0;
    err_inc    = 1'b0;
    frame_inc  = 1'b0;

    case (state_reg)
      SEARCH: begin
        // The sample at (0,0) is already accounted for; predict pixel 1.
        if (smp_vld_reg && (h_reg == 11'd0) && (v_reg == 11'd0)) begin
          state_next = TRACK;
          exp_h_next = 11'd1;
          exp_v_next = 11'd0;
        end
      end

      TRACK: begin
        if (mismatch) begin
          state_next = SEARCH;
          exp_h_next = '0;
          exp_v_next = '0;
        end else begin
          exp_h_next = exp_h_adv;
          exp_v_next = exp_v_adv;
          if (frame_wrap) begin
            state_next = LOCKED;
          end
        end
      end

      LOCKED: begin
        if (mismatch) begin
          state_next = SEARCH;
          exp_h_next = '0;
          exp_v_next = '0;
          set_err_h  = mis_h;
          set_err_v  = mis_v;
          set_err_s  = mis_s;
          err_inc    = 1'b1;
        end else begin
          exp_h_next = exp_h_adv;
          exp_v_next = exp_v_adv;
          frame_inc  = frame_wrap;
        end
      end

      default: begin
        state_next = SEARCH;
        exp_h_next = '0;
        exp_v_next = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, expected counters and reporting registers.
  // -------------------------------------------------------------------------
  logic        err_h_reg;
  logic        err_v_reg;
  logic        err_s_reg;
  logic [15:0] err_count_reg;
  logic [15:0] frame_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SEARCH;
      exp_h_reg     <= '0;
      exp_v_reg     <= '0;
      err_h_reg     <= 1'b0;
      err_v_reg     <= 1'b0;
      err_s_reg     <= 1'b0;
      err_count_reg <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      exp_h_reg <= exp_h_next;
      exp_v_reg <= exp_v_next;
      // Flags only ever get set here; the reset branch is the sole way out.
      if (set_err_h) err_h_reg <= 1'b1;
      if (set_err_v) err_v_reg <= 1'b1;
      if (set_err_s) err_s_reg <= 1'b1;
      if (err_inc && (err_count_reg != 16'hFFFF)) begin
        err_count_reg <= err_count_reg + 16'd1;
      end
      if (frame_inc) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
    end
  end

  assign locked     = (state_reg == LOCKED);
  assign err_hcount = err_h_reg;
  assign err_vcount = err_v_reg;
  assign err_count  = err_count_reg;
  assign frame_cnt  = frame_cnt_reg;

`ifdef VGA_MON_SYNC_CHECK_EN
  assign err_sync = err_s_reg;
`else
  // Strobe mismatches cannot occur in this build, so the flag never sets;
  // it is tied off explicitly and the (constant) register is left unread.
  logic unused_err_s;
  assign unused_err_s = err_s_reg;
  assign err_sync     = 1'b0;
`endif

endmodule
